// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write register file with registered reads and post-reset clear sweep.
// Optional same-edge write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              out_valid,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              hit_a, hit_b;
    logic [DATA_W-1:0] port_a, port_b;

    // Register 0 is hardwired to zero; a forwarding hit replaces the stored word.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              fwd_hit,
        input logic [DATA_W-1:0] fwd_data
    );
        if (addr == '0) begin
            return '0;
        end else if (fwd_hit) begin
            return fwd_data;
        end else begin
            return stored;
        end
    endfunction

`ifdef REGFILE_BYPASS_EN
    assign hit_a = we && (waddr == ra_addr);
    assign hit_b = we && (waddr == rb_addr);
`else
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
`endif

    assign port_a = resolve(ra_addr, mem_q[ra_addr], hit_a, wdata);
    assign port_b = resolve(rb_addr, mem_q[rb_addr], hit_b, wdata);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        valid_d   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        unique case (state_q)
            CLEAR: begin
                // Sweep one entry per edge; the last entry hands over to RUN.
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (re) begin
                    a_d     = port_a;
                    b_d     = port_b;
                    valid_d = 1'b1;
                end
                mem_we = we && (waddr != '0);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    // The array itself is left untouched on a reset edge; the sweep clears it.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign out_valid = valid_q;
    assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - self-checking bench for regfile_2r1w (vector table, corner sequences, random vs model).
module tb_regfile_2r1w;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst, re, we;
    logic [AW-1:0] ra_addr, rb_addr, waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] a, b;
    logic          out_valid, busy;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] m_mem [N];
    int            m_sweep;
    logic [DW-1:0] m_a, m_b;
    logic          m_v;

    typedef struct {
        logic          re;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        logic          ev;
    } vec_t;

    vec_t tbl [11];

    regfile_2r1w #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .re(re), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .we(we), .waddr(waddr), .wdata(wdata),
        .a(a), .b(b), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_port(input logic [AW-1:0] ad);
        if (ad == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == ad) return wdata;
`endif
        return m_mem[ad];
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_sweep = N;
            m_a = '0;
            m_b = '0;
            m_v = 1'b0;
        end else if (m_sweep > 0) begin
            m_mem[N - m_sweep] = '0;
            m_sweep--;
            m_v = 1'b0;
        end else begin
            if (re) begin
                m_a = m_port(ra_addr);
                m_b = m_port(rb_addr);
                m_v = 1'b1;
            end else begin
                m_v = 1'b0;
            end
            if (we && waddr != 0) m_mem[waddr] = wdata;
        end
    endtask

    task automatic tick(input logic r, input logic rre, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                        input logic wwe, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        rst = r; re = rre; ra_addr = ra; rb_addr = rb; we = wwe; waddr = wa; wdata = wd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model_a", a, m_a);
        check("model_b", b, m_b);
        check("model_valid", {31'b0, out_valid}, {31'b0, m_v});
        check("model_busy", {31'b0, busy}, {31'b0, (m_sweep > 0)});
    endtask

    // Runs sweep edges (with re/we to reg 4 asserted, which must be ignored) until busy drops.
    task automatic run_sweep(input string name);
        int n = 0;
        do begin
            tick(1'b0, 1'b1, 5'd4, 5'd7, 1'b1, 5'd4, 32'h77);
            n++;
        end while (busy && n < 100);
        check(name, n, 32);
    endtask

    initial begin
        logic [DW-1:0] held_a, held_b;
        for (int i = 0; i < N; i++) m_mem[i] = '0;

        tbl[0]  = '{1'b0, 5'd0,  5'd0,  1'b1, 5'd3,  32'h12345678, 32'h0, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 5'd0,  5'd0,  1'b1, 5'd31, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0};
        tbl[2]  = '{1'b1, 5'd3,  5'd31, 1'b0, 5'd0,  32'h0, 32'h12345678, 32'hFFFFFFFF, 1'b1};
        tbl[3]  = '{1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0, 32'h12345678, 32'hFFFFFFFF, 1'b0};
        tbl[4]  = '{1'b0, 5'd0,  5'd0,  1'b1, 5'd0,  32'hA5A5A5A5, 32'h12345678, 32'hFFFFFFFF, 1'b0};
        tbl[5]  = '{1'b1, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0, 32'h0, 32'h0, 1'b1};
        tbl[6]  = '{1'b0, 5'd0,  5'd0,  1'b1, 5'd5,  32'h1, 32'h0, 32'h0, 1'b0};
`ifdef REGFILE_BYPASS_EN
        tbl[7]  = '{1'b1, 5'd5,  5'd3,  1'b1, 5'd5,  32'h2, 32'h2, 32'h12345678, 1'b1};
`else
        tbl[7]  = '{1'b1, 5'd5,  5'd3,  1'b1, 5'd5,  32'h2, 32'h1, 32'h12345678, 1'b1};
`endif
        tbl[8]  = '{1'b1, 5'd5,  5'd5,  1'b0, 5'd0,  32'h0, 32'h2, 32'h2, 1'b1};
`ifdef REGFILE_BYPASS_EN
        tbl[9]  = '{1'b1, 5'd31, 5'd31, 1'b1, 5'd31, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 1'b1};
        tbl[10] = '{1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0, 32'h0BADF00D, 32'h0BADF00D, 1'b0};
`else
        tbl[9]  = '{1'b1, 5'd31, 5'd31, 1'b1, 5'd31, 32'h0BADF00D, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        tbl[10] = '{1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
`endif

        // Reset and first sweep; writes to reg 4 during the sweep are dropped.
        tick(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        check("reset_a", a, 32'h0);
        check("reset_b", b, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h1);
        run_sweep("sweep_len_first");
        tick(1'b0, 1'b1, 5'd4, 5'd4, 1'b0, 5'd0, 32'h0);
        check("reg4_ignored", a, 32'h0);
        check("reg4_valid", {31'b0, out_valid}, 32'h1);

        foreach (tbl[i]) begin
            tick(1'b0, tbl[i].re, tbl[i].ra, tbl[i].rb, tbl[i].we, tbl[i].wa, tbl[i].wd);
            check($sformatf("vec%0d_a", i), a, tbl[i].ea);
            check($sformatf("vec%0d_b", i), b, tbl[i].eb);
            check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ev});
        end

        // Hold on re=0 after a valid read.
        tick(1'b0, 1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 32'h0);
        held_a = a; held_b = b;
        tick(1'b0, 1'b0, 5'd9, 5'd10, 1'b0, 5'd0, 32'h0);
        check("hold_a", a, 32'h12345678);
        check("hold_b", b, 32'h2);
        check("hold_a_same", a, held_a);
        check("hold_valid", {31'b0, out_valid}, 32'h0);

        // Pre-filled entry is cleared by a one-cycle reset pulse.
        tick(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'hDEADBEEF);
        tick(1'b0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 32'h0);
        check("prefill_7", a, 32'hDEADBEEF);
        tick(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        run_sweep("sweep_len_prefill");
        tick(1'b0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 32'h0);
        check("cleared_7", a, 32'h0);
        check("cleared_7_valid", {31'b0, out_valid}, 32'h1);

        // Randomised traffic with rare resets.
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] ra, rb, wa;
            ra = AW'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, 31));
            wa = ($urandom_range(0, 2) == 0) ? ra : AW'($urandom_range(0, 31));
            tick(($urandom_range(0, 299) == 0), 1'($urandom), ra, rb, 1'($urandom), wa, $urandom);
        end

        // Fill the array so the mid-sweep restart has something to erase.
        tick(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        run_sweep("sweep_len_prefillall");
        for (int i = 1; i < N; i++) tick(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, AW'(i), 32'hC0DE0000 + i);
        tick(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        tick(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        run_sweep("sweep_len_restart");
        for (int i = 0; i < N; i++) begin
            tick(1'b0, 1'b1, AW'(i), AW'(N - 1 - i), 1'b0, 5'd0, 32'h0);
            check($sformatf("restart_a%0d", i), a, 32'h0);
            check($sformatf("restart_b%0d", i), b, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
